// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one byte-wide memory between
// instruction fetch and load/store; each access moves a big-endian 32-bit word.
module mem_port_arbiter #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_req,
    input  logic [31:0]          inst_addr,
    output logic                 inst_ack,
    output logic [31:0]          inst_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [31:0]          data_addr,
    input  logic [31:0]          data_wdata,
    output logic                 data_ack,
    output logic [31:0]          data_rdata,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic {OWNER_INST, OWNER_DATA} owner_t;

    state_t               state, state_next;
    owner_t               owner, last_grant;
    logic [1:0]           cnt;
    logic                 we_lat;
    logic [ADDR_BITS-1:0] base;
    logic [31:0]          wdata_lat;
    logic [31:0]          asm_word;
    logic                 grant_inst, grant_data;
    logic [ADDR_BITS-1:0] grant_addr;
    logic                 unused_addr_bits;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign unused_addr_bits = ^{inst_addr[31:ADDR_BITS], data_addr[31:ADDR_BITS]};

    // On a tie the requester not served last wins.
    always_comb begin
        grant_inst = inst_req && (!data_req || last_grant == OWNER_DATA);
        grant_data = data_req && !grant_inst;
        grant_addr = grant_inst ? inst_addr[ADDR_BITS-1:0] : data_addr[ADDR_BITS-1:0];
    end

    always_comb begin
        state_next = state;
        inst_ack   = 1'b0;
        data_ack   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (inst_req || data_req) state_next = XFER;
            end
            XFER: begin
                busy = 1'b1;
                if (cnt == 2'd3) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                inst_ack   = (owner == OWNER_INST);
                data_ack   = (owner == OWNER_DATA);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory outputs are registered one byte ahead so that during each XFER
    // cycle they already present base+cnt; outside XFER they simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWNER_INST;
            last_grant <= OWNER_DATA;
            cnt        <= '0;
            we_lat     <= 1'b0;
            base       <= '0;
            wdata_lat  <= '0;
            asm_word   <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_inst || grant_data) begin
                        owner     <= grant_inst ? OWNER_INST : OWNER_DATA;
                        base      <= grant_addr;
                        we_lat    <= grant_data && data_we;
                        wdata_lat <= data_wdata;
                        cnt       <= '0;
                        mem_addr  <= grant_addr;
                        mem_wdata <= data_wdata[31:24];
                        mem_we    <= grant_data && data_we;
                    end
                end
                XFER: begin
                    cnt <= cnt + 2'd1;
                    case (cnt)
                        2'd0:    asm_word[31:24] <= mem_rdata;
                        2'd1:    asm_word[23:16] <= mem_rdata;
                        2'd2:    asm_word[15:8]  <= mem_rdata;
                        default: asm_word[7:0]   <= mem_rdata;
                    endcase
                    if (cnt == 2'd3) begin
                        mem_we <= 1'b0;
                        if (!we_lat) begin
                            if (owner == OWNER_INST) inst_rdata <= {asm_word[31:8], mem_rdata};
                            else                     data_rdata <= {asm_word[31:8], mem_rdata};
                        end
                    end else begin
                        mem_addr  <= base + ADDR_BITS'(cnt + 2'd1);
                        mem_wdata <= word_byte(wdata_lat, cnt + 2'd1);
                    end
                end
                DONE: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;
    localparam int AB  = 16;
    localparam int MSZ = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_req = 1'b0;
    logic [31:0]   inst_addr = '0;
    logic          inst_ack;
    logic [31:0]   inst_rdata;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [31:0]   data_addr = '0;
    logic [31:0]   data_wdata = '0;
    logic          data_ack;
    logic [31:0]   data_rdata;
    logic          busy;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // The memory the DUT talks to.
    logic [7:0] mem [MSZ] = '{default: 8'h00};
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record plus a cycle index k since grant
    // (k=0..3 byte cycles, k=4 ack cycle), and its own copy of memory.
    logic [7:0]  ref_mem [MSZ] = '{default: 8'h00};
    bit          m_act = 1'b0;
    int          m_k = 0;
    bit          m_own = 1'b0;     // 0 = inst, 1 = data
    bit          m_last = 1'b1;
    int          m_base = 0;
    bit          m_we = 1'b0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_ird = '0;
    logic [31:0] m_drd = '0;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'(w >> (24 - 8 * k));
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        if (m_act && m_k < 4 && m_we) ref_mem[(m_base + m_k) % MSZ] = byte_of(m_wd, m_k);
        if (rst) begin
            m_act = 1'b0; m_k = 0; m_last = 1'b1; m_ird = '0; m_drd = '0;
        end else if (m_act) begin
            if (m_k == 3 && !m_we) begin
                w = {ref_mem[m_base % MSZ], ref_mem[(m_base + 1) % MSZ],
                     ref_mem[(m_base + 2) % MSZ], ref_mem[(m_base + 3) % MSZ]};
                if (m_own) m_drd = w; else m_ird = w;
            end
            if (m_k == 4) begin
                m_act = 1'b0; m_last = m_own;
            end else m_k++;
        end else if (inst_req || data_req) begin
            m_own  = (inst_req && data_req) ? !m_last : data_req;
            m_base = m_own ? int'(data_addr & 32'(MSZ - 1)) : int'(inst_addr & 32'(MSZ - 1));
            m_we   = m_own && data_we;
            m_wd   = data_wdata;
            m_k    = 0;
            m_act  = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic xfer;
        xfer = m_act && m_k < 4;
        chk("busy", 32'(busy), 32'(m_act));
        chk("inst_ack", 32'(inst_ack), 32'(m_act && m_k == 4 && !m_own));
        chk("data_ack", 32'(data_ack), 32'(m_act && m_k == 4 && m_own));
        chk("mem_we", 32'(mem_we), 32'(xfer && m_we));
        chk("inst_rdata", inst_rdata, m_ird);
        chk("data_rdata", data_rdata, m_drd);
        chk("one_ack", 32'(inst_ack && data_ack), 32'd0);
        if (xfer) chk("mem_addr", 32'(mem_addr), 32'((m_base + m_k) % MSZ));
        if (xfer && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(byte_of(m_wd, m_k)));
    end

    task automatic access(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        @(negedge clk);
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(is_data ? data_ack : inst_ack) && lat < 30);
        if (lat >= 30) chk("access_timeout", 32'(lat), 32'd5);
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int cyc_a [4];
        bit who [4];
        int iw, dw;
        logic [31:0] hi;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({inst_ack, data_ack}), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        rst = 1'b0;

        // Instruction fetch of a word placed at 0x100
        access(1'b1, 1'b1, 32'h0000_0100, 32'h8C22_0004, lat);
        access(1'b0, 1'b0, 32'h0000_0100, 32'h0, lat);
        chk("fetch_latency", 32'(lat), 32'd5);
        chk("fetch_word", inst_rdata, 32'h8C22_0004);

        // Store then load
        access(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, lat);
        chk("store_latency", 32'(lat), 32'd5);
        chk("store_bytes", {mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]}, 32'hDEAD_BEEF);
        chk("store_rdata_kept", data_rdata, 32'h0);
        access(1'b1, 1'b0, 32'h0000_2000, 32'h0, lat);
        chk("load_word", data_rdata, 32'hDEAD_BEEF);

        // Wrap at top of memory, and an unaligned load
        access(1'b1, 1'b1, 32'h0000_FFFE, 32'h1122_3344, lat);
        chk("wrap_bytes", {mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]}, 32'h1122_3344);
        access(1'b1, 1'b0, 32'h0000_FFFE, 32'h0, lat);
        chk("wrap_load", data_rdata, 32'h1122_3344);
        access(1'b1, 1'b1, 32'h0000_0004, 32'hA1B2_C3D4, lat);
        access(1'b1, 1'b0, 32'h0000_0003, 32'h0, lat);
        chk("unaligned_load", data_rdata, 32'h00A1_B2C3);

        // Upper address bits ignored
        access(1'b0, 1'b0, 32'hABCD_0100, 32'h0, lat);
        chk("upper_bits", inst_rdata, 32'h8C22_0004);

        // Simultaneous requests after reset, held continuously
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_2000;
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (inst_ack && n < 4) begin who[n] = 1'b0; cyc_a[n] = c; n++; end
            if (data_ack && n < 4) begin who[n] = 1'b1; cyc_a[n] = c; n++; end
        end
        inst_req = 1'b0; data_req = 1'b0;
        chk("tie_ack_count", 32'(n), 32'd4);
        chk("tie_first_ack", 32'(cyc_a[0]), 32'd5);
        for (int i = 0; i < 4; i++) chk("tie_order", 32'(who[i]), 32'(i % 2));
        for (int i = 0; i < 3; i++) chk("tie_spacing", 32'(cyc_a[i+1] - cyc_a[i]), 32'd6);
        repeat (8) @(negedge clk);

        // Reset during a store while the second byte is on the bus
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_3000; data_wdata = 32'hDEAD_BEEF;
        n = 0;
        while (!(mem_we && mem_addr == 16'h3001) && n < 20) begin
            @(negedge clk); n++;
        end
        chk("rst_store_reached", 32'(n < 20), 32'd1);
        rst = 1'b1; data_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mid_data_rdata", data_rdata, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_mid_no_ack", 32'(data_ack), 32'd0);
        end
        chk("rst_mid_bytes", {mem[16'h3000], mem[16'h3001], mem[16'h3002], mem[16'h3003]}, 32'hDEAD_0000);
        access(1'b0, 1'b0, 32'h0000_0100, 32'h0, lat);
        chk("post_rst_fetch_latency", 32'(lat), 32'd5);
        chk("post_rst_fetch", inst_rdata, 32'h8C22_0004);

        // Random traffic against the model
        iw = 0; dw = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = 1'b0;
            if (inst_req && inst_ack) begin inst_req = 1'b0; iw = 0; end
            if (data_req && data_ack) begin data_req = 1'b0; dw = 0; end
            if (inst_req) iw++;
            if (data_req) dw++;
            if (iw > 20) begin chk("rand_inst_timeout", 32'(iw), 32'd0); inst_req = 1'b0; iw = 0; end
            if (dw > 20) begin chk("rand_data_timeout", 32'(dw), 32'd0); data_req = 1'b0; dw = 0; end
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                hi = $urandom();
                case ($urandom_range(0, 2))
                    0:       inst_addr = {hi[31:16], 16'hFFF8 + 16'($urandom_range(0, 7))};
                    1:       inst_addr = {hi[31:16], 16'($urandom_range(0, 15))};
                    default: inst_addr = {hi[31:16], 16'h4000 + 16'($urandom_range(0, 31))};
                endcase
                inst_req = 1'b1;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                hi = $urandom();
                case ($urandom_range(0, 2))
                    0:       data_addr = {hi[31:16], 16'hFFF8 + 16'($urandom_range(0, 7))};
                    1:       data_addr = {hi[31:16], 16'($urandom_range(0, 15))};
                    default: data_addr = {hi[31:16], 16'h4000 + 16'($urandom_range(0, 31))};
                endcase
                data_we = 1'($urandom_range(0, 1));
                data_wdata = $urandom();
                data_req = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; iw = 0; dw = 0;
            end
        end
        @(negedge clk);
        rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one byte-wide, single-port memory between the instruction-fetch requester and the data (load/store) requester. Each granted access moves one 32-bit big-endian word as four sequential byte cycles. It gathers read bytes into a word, or splits a write word into bytes. It sits between the CPU front end / memory stage and a unified 2^ADDR_BITS-byte memory, replacing dedicated instruction-memory ports.

## Interface
- ADDR_BITS, 16, memory index width; upper address bits are ignored
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request, held until inst_ack
- inst_addr  in  32  fetch byte address
- inst_ack  out  1  one-cycle pulse: fetch complete
- inst_rdata  out  32  fetched word, valid with inst_ack, held until next fetch completes
- data_req  in  1  data request, held until data_ack
- data_we  in  1  1 = store, 0 = load (sampled at grant)
- data_addr  in  32  data byte address
- data_wdata  in  32  store word
- data_ack  out  1  one-cycle pulse: data access complete
- data_rdata  out  32  loaded word, valid with data_ack, held until next load completes
- busy  out  1  high in XFER and DONE
- mem_addr  out  ADDR_BITS  byte address to memory
- mem_wdata  out  8  byte to memory
- mem_we  out  1  byte write strobe, written at rising edge
- mem_rdata  in  8  combinational read byte at mem_addr

## Operation
- FSM states: IDLE, XFER, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If only one requester asserts req, grant it.
  - If both assert req, grant the one not granted last (round-robin `last_grant`).
  - On grant: latch owner, base = addr[ADDR_BITS-1:0], we (forced 0 for inst), and wdata. Set cnt=0. Go to XFER.
- **XFER**
  - mem_addr = base + cnt, computed modulo 2^ADDR_BITS (wraps at top of memory). Unaligned bases are legal.
  - Byte order is big-endian: cnt 0 carries word bits [31:24], cnt 3 carries bits [7:0].
  - Read: at each edge, capture mem_rdata into lane [31-8*cnt -: 8] of the assembly register.
  - Write: mem_wdata = wdata[31-8*cnt -: 8] and mem_we=1.
  - cnt increments each cycle. After cnt=3, go to DONE.
- **DONE**
  - Pulse the owner's ack for one cycle.
  - For a read, copy the assembled word to the owner's rdata register at the XFER→DONE edge, so it is valid during ack.
  - Update last_grant = owner. Go to IDLE.
- Request/address changes after grant are ignored until the next IDLE.
- A requester still asserting req in IDLE after its ack is treated as a new request.
- Reset values:
  - State IDLE, cnt 0, last_grant = DATA (inst wins the first tie).
  - inst_ack, data_ack, busy, mem_we: 0.
  - inst_rdata, data_rdata, mem_addr, mem_wdata: 0.
- Reset mid-transfer:
  - Return to IDLE immediately; no ack is issued.
  - mem_we goes 0 in the next cycle; bytes already written stay written.
  - rdata registers clear to 0.
- mem_we, mem_addr and mem_wdata are driven only in XFER. Elsewhere mem_we=0 and address/data hold their last value (0 after reset).

## Timing
- Grant edge E (IDLE sees req): XFER cycles follow edges E..E+3; ack is high in the cycle after edge E+4.
- Latency: 5 cycles from sampled req to ack.
- Back-to-back throughput: one access per 6 cycles (grant IDLE, 4 XFER, DONE).
- Requester deasserts req at the edge ending the ack cycle, or is re-granted.
- At most one ack is high in any cycle; acks never occur outside DONE.
- mem_we is high for exactly 4 consecutive cycles per store.

## Test plan
- **Inst fetch:** mem[0x100..0x103] = 8C,22,00,04; inst_req with inst_addr=0x100 → inst_ack 5 cycles after grant, inst_rdata=0x8C220004; mem_addr sequence 0x100..0x103; mem_we stays 0.
- **Store then load:** data_we=1, data_addr=0x2000, data_wdata=0xDEADBEEF → mem[0x2000..0x2003] = DE,AD,BE,EF, data_ack, data_rdata unchanged. Then load 0x2000 → data_rdata=0xDEADBEEF.
- **Simultaneous requests after reset, held continuously:**
  - Grant order: inst, data, inst, data.
  - Acks spaced 6 cycles apart.
  - No cycle has both acks high.
- **Wrap-around:** load at addr 0xFFFE (ADDR_BITS=16) → bytes from 0xFFFE, 0xFFFF, 0x0000, 0x0001. Unaligned 0x0003 is assembled correctly.
- **Reset during store at cnt=1:**
  - Only bytes 0–1 are written.
  - No data_ack; busy=0 and mem_we=0 after reset.
  - A later inst_req is served normally.
- **Upper address bits ignored:** inst_addr=0xABCD0100 returns the same word as 0x00000100.
